// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and helpers for the data memory sequencing controller.
package data_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_t;

  function automatic logic [2:0] size_bytes(input size_t sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_byte_lane_unit.sv
// Big-endian lane steering: sub-word store merge and load extraction with extension.
module byte_lane_unit
  import data_mem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  logic [4:0]  byte_sh_s;
  logic [4:0]  half_sh_s;
  logic [31:0] byte_lane_s;
  logic [31:0] half_lane_s;

  // Offset 0 is the most significant lane, so the shift counts down from the top.
  assign byte_sh_s   = {~offset, 3'b000};
  assign half_sh_s   = {~offset[1], 4'b0000};
  assign byte_lane_s = word >> byte_sh_s;
  assign half_lane_s = word >> half_sh_s;

  // Merge and extract for the addressed lane.
  always_comb begin
    merged    = word;
    extracted = 32'h0000_0000;
    case (size)
      SZ_BYTE: begin
        merged    = (word & ~(32'h0000_00FF << byte_sh_s)) | ({24'h00_0000, wdata[7:0]} << byte_sh_s);
        extracted = sign ? {{24{byte_lane_s[7]}}, byte_lane_s[7:0]} : {24'h00_0000, byte_lane_s[7:0]};
      end
      SZ_HALF: begin
        merged    = (word & ~(32'h0000_FFFF << half_sh_s)) | ({16'h0000, wdata[15:0]} << half_sh_s);
        extracted = sign ? {{16{half_lane_s[15]}}, half_lane_s[15:0]} : {16'h0000, half_lane_s[15:0]};
      end
      SZ_WORD: begin
        merged    = wdata;
        extracted = word;
      end
      default: begin
        merged    = word;
        extracted = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// CPU load/store sequencer for a word-wide big-endian RAM with read-modify-write sub-word stores.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] ram_address,
  output logic [31:0] ram_writedata,
  output logic        ram_write_en,
  output logic        ram_read_en,
  input  logic [31:0] ram_readdata
);

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t      state_r;
  logic [1:0]  offset_r;
  logic [1:0]  size_r;
  logic        signed_r;
  logic        write_r;
  logic [31:0] wdata_r;
  logic [31:0] ram_address_r;
  logic [31:0] ram_writedata_r;
  logic        ram_write_en_r;
  logic        ram_read_en_r;
  logic        resp_valid_r;
  logic        resp_err_r;
  logic [31:0] resp_rdata_r;

  logic        err_s;
  logic [2:0]  bytes_s;
  logic [32:0] last_s;
  logic [31:0] merged_s;
  logic [31:0] extracted_s;

  // Request legality: size, alignment, and last touched byte inside the RAM.
  always_comb begin
    err_s   = 1'b0;
    bytes_s = 3'd0;
    last_s  = 33'd0;
    if (req_size == 2'b11) begin
      err_s = 1'b1;
    end else begin
      bytes_s = size_bytes(size_t'(req_size));
      last_s  = {1'b0, req_addr} + {30'd0, bytes_s} - 33'd1;
      if (req_size == SZ_HALF && req_addr[0]) begin
        err_s = 1'b1;
      end else if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) begin
        err_s = 1'b1;
      end else if (last_s >= MEM_LIMIT) begin
        err_s = 1'b1;
      end else begin
        err_s = 1'b0;
      end
    end
  end

  byte_lane_unit u_lane (
    .word      (ram_readdata),
    .wdata     (wdata_r),
    .offset    (offset_r),
    .size      (size_r),
    .sign      (signed_r),
    .merged    (merged_s),
    .extracted (extracted_s)
  );

  // Sequencer FSM; every output is set on the edge that enters the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      offset_r        <= 2'b00;
      size_r          <= 2'b00;
      signed_r        <= 1'b0;
      write_r         <= 1'b0;
      wdata_r         <= 32'h0000_0000;
      ram_address_r   <= 32'h0000_0000;
      ram_writedata_r <= 32'h0000_0000;
      ram_write_en_r  <= 1'b0;
      ram_read_en_r   <= 1'b0;
      resp_valid_r    <= 1'b0;
      resp_err_r      <= 1'b0;
      resp_rdata_r    <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            offset_r      <= req_addr[1:0];
            size_r        <= req_size;
            signed_r      <= req_signed;
            write_r       <= req_write;
            wdata_r       <= req_wdata;
            ram_address_r <= {req_addr[31:2], 2'b00};
            if (err_s) begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 32'h0000_0000;
            end else if (req_write && req_size == SZ_WORD) begin
              state_r         <= WR;
              ram_write_en_r  <= 1'b1;
              ram_writedata_r <= req_wdata;
            end else begin
              state_r       <= RD;
              ram_read_en_r <= 1'b1;
            end
          end
        end
        RD: begin
          ram_read_en_r <= 1'b0;
          if (write_r) begin
            state_r         <= WR;
            ram_write_en_r  <= 1'b1;
            ram_writedata_r <= merged_s;
          end else begin
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= extracted_s;
          end
        end
        WR: begin
          state_r         <= RESP;
          ram_write_en_r  <= 1'b0;
          ram_writedata_r <= 32'h0000_0000;
          resp_valid_r    <= 1'b1;
          resp_err_r      <= 1'b0;
          resp_rdata_r    <= 32'h0000_0000;
        end
        RESP: begin
          state_r      <= IDLE;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= 32'h0000_0000;
        end
        default: begin
          state_r         <= IDLE;
          ram_write_en_r  <= 1'b0;
          ram_read_en_r   <= 1'b0;
          ram_writedata_r <= 32'h0000_0000;
          resp_valid_r    <= 1'b0;
          resp_err_r      <= 1'b0;
          resp_rdata_r    <= 32'h0000_0000;
        end
      endcase
    end
  end

  assign req_ready     = (state_r == IDLE) && rst_n;
  assign resp_valid    = resp_valid_r;
  assign resp_err      = resp_err_r;
  assign resp_rdata    = resp_rdata_r;
  assign ram_address   = ram_address_r;
  assign ram_writedata = ram_writedata_r;
  assign ram_write_en  = ram_write_en_r;
  assign ram_read_en   = ram_read_en_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a small behavioural RAM attached.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] ram_address;
  logic [31:0] ram_writedata;
  logic        ram_write_en;
  logic        ram_read_en;
  logic [31:0] ram_readdata;

  logic [31:0] mem [0:31];
  logic        preload;
  int          n_cmp;
  int          n_fail;

  data_mem_ctrl #(.MEM_BYTES(128)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_size      (req_size),
    .req_signed    (req_signed),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_err      (resp_err),
    .resp_rdata    (resp_rdata),
    .ram_address   (ram_address),
    .ram_writedata (ram_writedata),
    .ram_write_en  (ram_write_en),
    .ram_read_en   (ram_read_en),
    .ram_readdata  (ram_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_readdata = mem[ram_address[6:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0000_0000;
      mem[8]  <= 32'hCAFE_F00D;
      mem[31] <= 32'h0123_4567;
    end else if (ram_write_en) begin
      mem[ram_address[6:2]] <= ram_writedata;
    end
  end

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int nrd, output int nwr);
    int guard;
    lat = 0; rd = 32'h0; er = 1'b0; nrd = 0; nwr = 0;
    @(negedge clk);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h1234_5678;
    req_size = 2'b11; req_write = ~w; req_signed = ~sg;
    for (int c = 1; c <= 8; c++) begin
      if (ram_read_en) nrd++;
      if (ram_write_en) nwr++;
      if (resp_valid) begin
        lat = c; rd = resp_rdata; er = resp_err;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({req_ready, resp_valid, resp_err, ram_write_en, ram_read_en} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000", {req_ready, resp_valid, resp_err, ram_write_en, ram_read_en});
    end
    n_cmp++;
    if ({resp_rdata, ram_address, ram_writedata} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", {resp_rdata, ram_address, ram_writedata});
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_word_store_load;
    int lat, nrd, nwr;
    logic [31:0] rd;
    logic er;
    do_req(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, lat, rd, er, nrd, nwr);
    n_cmp++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0 || nwr !== 1 || nrd !== 0) begin
      n_fail++;
      $display("FAIL sw_resp: lat=%0d err=%b rdata=%h wr=%0d rd=%0d want 2 0 0 1 0", lat, er, rd, nwr, nrd);
    end
    n_cmp++;
    if (mem[4] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL sw_mem: got %h want deadbeef", mem[4]);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, lat, rd, er, nrd, nwr);
    n_cmp++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEAD_BEEF || nrd !== 1 || nwr !== 0) begin
      n_fail++;
      $display("FAIL lw_resp: lat=%0d err=%b rdata=%h want 2 0 deadbeef", lat, er, rd);
    end
  endtask

  task automatic test_byte_rmw;
    int lat, nrd, nwr;
    logic [31:0] rd;
    logic er;
    do_req(1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'hAAAA_AA55, lat, rd, er, nrd, nwr);
    n_cmp++;
    if (lat !== 3 || er !== 1'b0 || nwr !== 1 || nrd !== 1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL sb_resp: lat=%0d err=%b wr=%0d rd=%0d want 3 0 1 1", lat, er, nwr, nrd);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, lat, rd, er, nrd, nwr);
    n_cmp++;
    if (rd !== 32'hDE55_BEEF || er !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_readback: got %h want de55beef", rd);
    end
  endtask

  task automatic test_extension;
    logic [31:0] addr_t [0:5];
    logic [1:0]  size_t_v [0:5];
    logic        sgn_t [0:5];
    logic [31:0] exp_t [0:5];
    int lat, nrd, nwr;
    logic [31:0] rd;
    logic er;
    addr_t[0] = 32'h10; size_t_v[0] = 2'b00; sgn_t[0] = 1'b1; exp_t[0] = 32'hFFFF_FFDE;
    addr_t[1] = 32'h10; size_t_v[1] = 2'b00; sgn_t[1] = 1'b0; exp_t[1] = 32'h0000_00DE;
    addr_t[2] = 32'h12; size_t_v[2] = 2'b01; sgn_t[2] = 1'b1; exp_t[2] = 32'hFFFF_BEEF;
    addr_t[3] = 32'h12; size_t_v[3] = 2'b01; sgn_t[3] = 1'b0; exp_t[3] = 32'h0000_BEEF;
    addr_t[4] = 32'h11; size_t_v[4] = 2'b00; sgn_t[4] = 1'b1; exp_t[4] = 32'h0000_0055;
    addr_t[5] = 32'h10; size_t_v[5] = 2'b01; sgn_t[5] = 1'b0; exp_t[5] = 32'h0000_DE55;
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, size_t_v[i], sgn_t[i], addr_t[i], 32'h0, lat, rd, er, nrd, nwr);
      n_cmp++;
      if (rd !== exp_t[i] || er !== 1'b0 || lat !== 2) begin
        n_fail++;
        $display("FAIL ext_%0d: rdata=%h err=%b lat=%0d want %h 0 2", i, rd, er, lat, exp_t[i]);
      end
    end
  endtask

  task automatic test_errors;
    logic [31:0] addr_t [0:3];
    logic [1:0]  sz_t [0:3];
    logic        wr_t [0:3];
    int lat, nrd, nwr;
    logic [31:0] rd;
    logic er;
    addr_t[0] = 32'h11; sz_t[0] = 2'b01; wr_t[0] = 1'b0;
    addr_t[1] = 32'h12; sz_t[1] = 2'b10; wr_t[1] = 1'b1;
    addr_t[2] = 32'h7E; sz_t[2] = 2'b10; wr_t[2] = 1'b0;
    addr_t[3] = 32'h00; sz_t[3] = 2'b11; wr_t[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_req(wr_t[i], sz_t[i], 1'b0, addr_t[i], 32'hFFFF_FFFF, lat, rd, er, nrd, nwr);
      n_cmp++;
      if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || nrd !== 0 || nwr !== 0) begin
        n_fail++;
        $display("FAIL err_%0d: lat=%0d err=%b rdata=%h rd=%0d wr=%0d want 1 1 0 0 0", i, lat, er, rd, nrd, nwr);
      end
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_007C, 32'h0, lat, rd, er, nrd, nwr);
    n_cmp++;
    if (rd !== 32'h0123_4567 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL top_word: rdata=%h err=%b want 01234567 0", rd, er);
    end
    do_req(1'b0, 2'b00, 1'b0, 32'h0000_007F, 32'h0, lat, rd, er, nrd, nwr);
    n_cmp++;
    if (rd !== 32'h0000_0067 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL top_byte: rdata=%h err=%b want 00000067 0", rd, er);
    end
  endtask

  task automatic test_reset_mid_rmw;
    int lat, nrd, nwr;
    logic [31:0] rd;
    logic er;
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h20; req_wdata = 32'h11;
    req_valid = 1'b1;
    for (int g = 0; g < 20 && !req_ready; g++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_cmp++;
    if (ram_read_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rmw_rd_phase: ram_read_en=%b want 1", ram_read_en);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, resp_valid, resp_err, ram_write_en, ram_read_en} !== 5'b00000 ||
        {resp_rdata, ram_address, ram_writedata} !== 96'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outs: ctrl=%b data=%h want 0", {req_ready, resp_valid, resp_err, ram_write_en, ram_read_en},
               {resp_rdata, ram_address, ram_writedata});
    end
    @(posedge clk); #1;
    n_cmp++;
    if (resp_valid !== 1'b0 || mem[8] !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL mid_reset_nowrite: resp_valid=%b mem=%h want 0 cafef00d", resp_valid, mem[8]);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_ready: got %b want 1", req_ready);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, lat, rd, er, nrd, nwr);
    n_cmp++;
    if (rd !== 32'hCAFE_F00D || er !== 1'b0 || lat !== 2) begin
      n_fail++;
      $display("FAIL mid_reset_readback: rdata=%h err=%b lat=%0d want cafef00d 0 2", rd, er, lat);
    end
  endtask

  task automatic test_back_to_back;
    int acc [0:1];
    int nacc;
    logic [31:0] resp_q [$];
    logic acc_now;
    acc[0] = -1; acc[1] = -1; nacc = 0;
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
    req_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      acc_now = req_valid && req_ready;
      @(posedge clk); #1;
      if (acc_now) begin
        if (nacc < 2) acc[nacc] = c;
        nacc++;
        if (nacc == 1) begin
          req_size = 2'b00; req_addr = 32'h13;
        end else begin
          req_valid = 1'b0;
        end
      end
      if (resp_valid) resp_q.push_back(resp_rdata);
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_cmp++;
    if (nacc !== 2 || acc[1] - acc[0] !== 3) begin
      n_fail++;
      $display("FAIL busy_accept: accepts=%0d spacing=%0d want 2 3", nacc, acc[1] - acc[0]);
    end
    n_cmp++;
    if (resp_q.size() !== 2) begin
      n_fail++;
      $display("FAIL busy_resp_count: got %0d want 2", resp_q.size());
    end else if (resp_q[0] !== 32'hDE55_BEEF || resp_q[1] !== 32'h0000_00EF) begin
      n_fail++;
      $display("FAIL busy_resp_order: got %h %h want de55beef 000000ef", resp_q[0], resp_q[1]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;
    test_reset;
    test_word_store_load;
    test_byte_rmw;
    test_extension;
    test_errors;
    test_reset_mid_rmw;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
